// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern/length, overlap
// control, build-time Mealy or Moore output timing and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          LEN_W       = 4,
    parameter int unsigned          CNT_W       = 8,
    parameter bit                   MEALY       = 1'b1,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b0000_1010,
    parameter int unsigned          DEF_LEN     = 4,
    parameter bit                   DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count
);

    localparam int unsigned FW = $clog2(MAX_LEN + 1);
    localparam int unsigned CW = ((FW > LEN_W) ? FW : LEN_W) + 1;

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    // The oldest history bit never reaches a compare, so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0] hist_q;
    logic [FW-1:0]      fill_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               match_now;

    assign cand = {hist_q, x};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign match_now = !rst && !cfg_load && (len_q != '0)
                    && ((CW'(fill_q) + CW'(1)) >= CW'(len_q))
                    && (((cand ^ pattern_q) & mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
            overlap_q <= cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
        end else begin
            hist_q <= cand[MAX_LEN-2:0];
            // Non-overlap mode restarts the fill count so the next match needs fresh bits.
            if (match_now && !overlap_q) begin
                fill_q <= '0;
            end else if (fill_q != FW'(MAX_LEN)) begin
                fill_q <= fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_q <= '0;
        end else if (match_now && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_count = cnt_q;

    generate
        if (MEALY) begin : g_mealy
            assign y = match_now;
        end else begin : g_moore
            logic y_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_q <= 1'b0;
                end else begin
                    y_q <= match_now;
                end
            end
            assign y = y_q;
        end
    endgenerate

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a Mealy, a Moore and a 2-bit-counter
// instance share one stimulus stream; expected values are hand-computed.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst, x, cfg_load, cfg_overlap, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       y_mealy, y_moore, y_small;
    logic [7:0] cnt_mealy, cnt_moore;
    logic [1:0] cnt_small;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.MEALY(1'b1)) u_mealy (
        .clk(clk), .rst(rst), .x(x), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .y(y_mealy), .match_count(cnt_mealy)
    );

    seq_detector_param #(.MEALY(1'b0)) u_moore (
        .clk(clk), .rst(rst), .x(x), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .y(y_moore), .match_count(cnt_moore)
    );

    seq_detector_param #(.MEALY(1'b1), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .x(x), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .y(y_small), .match_count(cnt_small)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // One serial bit: Mealy outputs checked before the edge, Moore output after it.
    task automatic send(input logic b, input logic ey);
        x = b;
        #2;
        chk("mealy_y", {31'd0, y_mealy}, {31'd0, ey});
        chk("small_y", {31'd0, y_small}, {31'd0, ey});
        @(posedge clk);
        #1;
        chk("moore_y", {31'd0, y_moore}, {31'd0, ey});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        x   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // x is held high during the load cycle; it must be discarded.
    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                        input logic clr);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cnt_clr     = clr;
        x           = 1'b1;
        #2;
        chk("load_mealy_y", {31'd0, y_mealy}, 32'd0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
        chk("load_moore_y", {31'd0, y_moore}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_overlap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_mealy_y", {31'd0, y_mealy}, 32'd0);
        chk("rst_moore_y", {31'd0, y_moore}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_mealy}, 32'd0);
        chk("rst_cnt_moore", {24'd0, cnt_moore}, 32'd0);

        // Default 1010, len 4, overlap
        send(1, 0); send(0, 0); send(1, 0); send(0, 1);
        send(1, 0); send(0, 1); send(1, 0); send(0, 1);
        chk("t1_cnt", {24'd0, cnt_mealy}, 32'd3);
        chk("t1_cnt_moore", {24'd0, cnt_moore}, 32'd3);

        // Non-overlap 1010
        load(8'b0000_1010, 4'd4, 1'b0, 1'b1);
        chk("t2_cnt_clr", {24'd0, cnt_mealy}, 32'd0);
        send(1, 0); send(0, 0); send(1, 0); send(0, 1);
        send(1, 0); send(0, 0); send(1, 0); send(0, 1);
        chk("t2_cnt", {24'd0, cnt_mealy}, 32'd2);
        chk("t2_cnt_moore", {24'd0, cnt_moore}, 32'd2);

        // 111, len 3, overlap then non-overlap
        load(8'b0000_0111, 4'd3, 1'b1, 1'b1);
        send(1, 0); send(1, 0); send(1, 1); send(1, 1); send(1, 1);
        chk("t3_ov_cnt", {24'd0, cnt_mealy}, 32'd3);
        load(8'b0000_0111, 4'd3, 1'b0, 1'b1);
        send(1, 0); send(1, 0); send(1, 1); send(1, 0); send(1, 0);
        chk("t3_nov_cnt", {24'd0, cnt_mealy}, 32'd1);

        // Reset mid-sequence restores defaults and discards history
        do_reset();
        send(1, 0); send(0, 0); send(1, 0);
        do_reset();
        send(0, 0);
        send(1, 0); send(0, 0); send(1, 0); send(0, 1);
        chk("t4_cnt", {24'd0, cnt_mealy}, 32'd1);

        // Length-1 pattern, saturation of the 2-bit counter, clear beats increment
        load(8'b0000_0001, 4'd1, 1'b1, 1'b1);
        send(1, 1); chk("t5_small_1", {30'd0, cnt_small}, 32'd1);
        send(1, 1); chk("t5_small_2", {30'd0, cnt_small}, 32'd2);
        send(1, 1); chk("t5_small_3", {30'd0, cnt_small}, 32'd3);
        send(1, 1); chk("t5_small_4", {30'd0, cnt_small}, 32'd3);
        send(1, 1); chk("t5_small_5", {30'd0, cnt_small}, 32'd3);
        send(1, 1); chk("t5_small_6", {30'd0, cnt_small}, 32'd3);
        chk("t5_big_cnt", {24'd0, cnt_mealy}, 32'd6);
        cnt_clr = 1'b1;
        send(1, 1);
        cnt_clr = 1'b0;
        chk("t5_clr_small", {30'd0, cnt_small}, 32'd0);
        chk("t5_clr_big", {24'd0, cnt_mealy}, 32'd0);

        // Length 0 disables detection
        load(8'b1111_1111, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send(1'($urandom_range(0, 1)), 0);
        end
        chk("t6_len0_cnt", {24'd0, cnt_mealy}, 32'd0);

        // Over-long length clamps to MAX_LEN
        load(8'b1011_0011, 4'd11, 1'b1, 1'b1);
        send(1, 0); send(0, 0); send(1, 0); send(1, 0);
        send(0, 0); send(0, 0); send(1, 0); send(1, 1);
        chk("t6_clamp_cnt", {24'd0, cnt_mealy}, 32'd1);

        // The x=1 in the load cycle must not form the first pattern bit
        load(8'b0000_1010, 4'd4, 1'b1, 1'b1);
        send(0, 0); send(1, 0); send(0, 0); send(1, 0); send(0, 1);
        chk("t6_load_x_cnt", {24'd0, cnt_mealy}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
